io_input_conditioner: RTL and testbench
=======================================

Name: io_input_conditioner

Overview:
- Parametrised front end between board switches/buttons and the CPU's MMIO input registers.
- Per bit: synchroniser, then debouncer.
- Per button: single-cycle press pulse.
- Button 0 captures a switch snapshot, held under a valid/ack handshake until the CPU consumes it.

Parameters:
- SW_WIDTH, 8, number of switch inputs.
- BTN_COUNT, 1, number of button inputs (>=1).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised value must differ from the stable value before it is accepted (>=1). Board builds set ~1_000_000.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- switches  in  SW_WIDTH  raw asynchronous switch levels.
- button  in  BTN_COUNT  raw asynchronous button levels, 1 = pressed.
- sw_stable  out  SW_WIDTH  debounced switch levels.
- btn_level  out  BTN_COUNT  debounced button levels.
- btn_press  out  BTN_COUNT  one-cycle pulse on each debounced 0->1 of the button.
- sw_snapshot  out  SW_WIDTH  sw_stable value captured on btn_press[0].
- snapshot_valid  out  1  sw_snapshot holds an unconsumed capture.
- snapshot_ack  in  1  consumer accepts the snapshot; sampled when snapshot_valid=1.

Behaviour:
- Reset (rst=1 at a clk edge): all sync flops, debounce counters, sw_stable, btn_level, btn_press, sw_snapshot, snapshot_valid (and overrun when enabled) become 0 on that edge. Reset mid-debounce discards the partial count.
- Synchroniser: SYNC_STAGES-deep shift per bit; the last stage is s.
- Debounce cell, per bit, with stable value q and counter cnt of width $clog2(DEBOUNCE_CYCLES)+1:
  - s==q: cnt<=0.
  - s!=q and cnt==DEBOUNCE_CYCLES-1: q<=s, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - Any return of s to q before acceptance clears cnt, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: an input change sampled at edge 0 and held thereafter appears on q after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults: visible 5 edges later; an input held constant for >=6 sampling edges is guaranteed visible.
- btn_press[i] = registered (btn_level[i] & ~btn_level_d[i]). It asserts one cycle after btn_level rises and lasts exactly one cycle. A held button never re-pulses. Release produces no pulse.
- Snapshot handshake, evaluated on each edge:
  - btn_press[0]=1: sw_snapshot<=sw_stable, snapshot_valid<=1. Capture wins even if snapshot_ack=1 in the same cycle.
  - Else if snapshot_valid & snapshot_ack: snapshot_valid<=0; sw_snapshot holds its value.
  - snapshot_ack while snapshot_valid=0 is ignored.
- Buttons 1..BTN_COUNT-1 affect only btn_level/btn_press.

Optional Feature:
- Macro IO_SNAPSHOT_OVERRUN_EN.
- Defined:
  - Extra output overrun (1 bit, reset 0) is set when btn_press[0]=1 while snapshot_valid=1 and snapshot_ack=0, i.e. an unconsumed capture is overwritten.
  - Sticky; cleared only by rst or by snapshot_valid & snapshot_ack with no simultaneous press.
  - The new capture is still stored.
- Undefined: port absent; overwrite is silent.

Decomposition:
- Package io_pkg holds:
  - default parameter constants (IO_SW_WIDTH=8, IO_BTN_COUNT=1, IO_SYNC_STAGES=2, IO_DEBOUNCE_SIM=4, IO_DEBOUNCE_BOARD=1_000_000);
  - a function computing counter width from DEBOUNCE_CYCLES.
- Sub-module io_debounce_cell: one bit of synchroniser plus debouncer, parameters SYNC_STAGES and DEBOUNCE_CYCLES, ports clk, rst, d, q. Instantiated SW_WIDTH+BTN_COUNT times via generate.
- Edge detect and snapshot logic stay in the top module.

Test Plan:
- Default params. Reset released; switches=8'h15 from edge 0 and held -> sw_stable=8'h00 through edge 4, 8'h15 after edge 5.
- switches 8'h15->8'h95 for 3 cycles, then back to 8'h15 -> sw_stable stays 8'h15 throughout; all counters return to 0.
- button[0] 0->1 held 20 cycles with sw_stable=8'h15 -> btn_press[0] high exactly one cycle; sw_snapshot=8'h15, snapshot_valid=1. Release gives no pulse.
- Without ack, switches->8'h6D, second press -> sw_snapshot=8'h6D, snapshot_valid=1. With IO_SNAPSHOT_OVERRUN_EN, overrun=1. Then snapshot_ack one cycle -> snapshot_valid=0, overrun=0, sw_snapshot still 8'h6D.
- btn_press[0] coincident with snapshot_ack while valid=1 -> valid remains 1, new value captured, no overrun.
- rst pulsed 1 cycle mid-debounce (cnt=2) and while snapshot_valid=1 -> next cycle all outputs 0; held input is re-accepted a full SYNC_STAGES+DEBOUNCE_CYCLES later.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: default parameters and counter sizing for io_input_conditioner
package io_pkg;
    localparam int IO_SW_WIDTH       = 8;
    localparam int IO_BTN_COUNT      = 1;
    localparam int IO_SYNC_STAGES    = 2;
    localparam int IO_DEBOUNCE_SIM   = 4;
    localparam int IO_DEBOUNCE_BOARD = 1_000_000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction
endpackage

// File: rtl/io_input_conditioner_if.sv
// io_input_conditioner_if: snapshot valid/ack handshake; overrun exists only with IO_SNAPSHOT_OVERRUN_EN
interface io_input_conditioner_if #(parameter int SW_WIDTH = io_pkg::IO_SW_WIDTH);
    logic [SW_WIDTH-1:0] sw_snapshot;
    logic                snapshot_valid;
    logic                snapshot_ack;
`ifdef IO_SNAPSHOT_OVERRUN_EN
    logic                overrun;
    modport master(output sw_snapshot, snapshot_valid, overrun, input snapshot_ack);
    modport slave(input sw_snapshot, snapshot_valid, overrun, output snapshot_ack);
`else
    modport master(output sw_snapshot, snapshot_valid, input snapshot_ack);
    modport slave(input sw_snapshot, snapshot_valid, output snapshot_ack);
`endif
endinterface

// File: rtl/io_debounce_cell.sv
// io_debounce_cell: one-bit synchroniser followed by a consecutive-difference debouncer
module io_debounce_cell
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = IO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // any return of s to q restarts the count, so short glitches never reach q
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            if (s == q) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                q   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: debounced switches/buttons, press pulses and a button-0 switch snapshot.
// Define IO_SNAPSHOT_OVERRUN_EN to flag captures that overwrite an unconsumed snapshot.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int SW_WIDTH        = IO_SW_WIDTH,
    parameter int BTN_COUNT       = IO_BTN_COUNT,
    parameter int SYNC_STAGES     = IO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_SIM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic [BTN_COUNT-1:0]  button,
    output logic [SW_WIDTH-1:0]   sw_stable,
    output logic [BTN_COUNT-1:0]  btn_level,
    output logic [BTN_COUNT-1:0]  btn_press,
    io_input_conditioner_if.master snap
);
    localparam int N = SW_WIDTH + BTN_COUNT;

    logic [N-1:0]         raw;
    logic [N-1:0]         clean;
    logic [BTN_COUNT-1:0] btn_level_d;

    assign raw = {button, switches};

    for (genvar i = 0; i < N; i++) begin : g_cell
        io_debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .d  (raw[i]),
            .q  (clean[i])
        );
    end

    assign sw_stable = clean[SW_WIDTH-1:0];
    assign btn_level = clean[N-1:SW_WIDTH];

    // a new capture takes priority over a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level_d         <= '0;
            btn_press           <= '0;
            snap.sw_snapshot    <= '0;
            snap.snapshot_valid <= 1'b0;
        end else begin
            btn_level_d <= btn_level;
            btn_press   <= btn_level & ~btn_level_d;
            if (btn_press[0]) begin
                snap.sw_snapshot    <= sw_stable;
                snap.snapshot_valid <= 1'b1;
            end else if (snap.snapshot_valid && snap.snapshot_ack) begin
                snap.snapshot_valid <= 1'b0;
            end
        end
    end

`ifdef IO_SNAPSHOT_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            snap.overrun <= 1'b0;
        end else if (btn_press[0]) begin
            if (snap.snapshot_valid && !snap.snapshot_ack) snap.overrun <= 1'b1;
        end else if (snap.snapshot_valid && snap.snapshot_ack) begin
            snap.overrun <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed plan plus random stimulus against a window-based reference model
module tb_io_input_conditioner;
    import io_pkg::*;

    localparam int SY  = IO_SYNC_STAGES;
    localparam int DB  = IO_DEBOUNCE_SIM;
    localparam int LEN = SY + DB - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] switches = '0;
    logic [0:0] button = '0;
    logic [7:0] sw_stable;
    logic [0:0] btn_level, btn_press;

    io_input_conditioner_if #(.SW_WIDTH(8)) sif ();

    io_input_conditioner dut (
        .clk      (clk),
        .rst      (rst),
        .switches (switches),
        .button   (button),
        .sw_stable(sw_stable),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .snap     (sif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference: q flips once the last DB synchronised samples all disagree with it
    logic [8:0] h [LEN];
    logic [8:0] m_q;
    logic       m_lvl_d, m_press, m_valid, m_ovr;
    logic [7:0] m_snap;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        logic [8:0] diff;
        if (rst) begin
            foreach (h[k]) h[k] = '0;
            m_q = '0; m_lvl_d = 0; m_press = 0; m_valid = 0; m_ovr = 0; m_snap = '0;
        end else begin
            diff = '1;
            for (int j = 0; j < DB; j++) diff &= h[SY-1+j] ^ m_q;
            if (m_press) begin
                if (m_valid && !sif.snapshot_ack) m_ovr = 1;
                m_snap  = m_q[7:0];
                m_valid = 1;
            end else if (m_valid && sif.snapshot_ack) begin
                m_valid = 0;
                m_ovr   = 0;
            end
            m_press = m_q[8] & ~m_lvl_d;
            m_lvl_d = m_q[8];
            m_q     = m_q ^ diff;
            for (int k = LEN - 1; k > 0; k--) h[k] = h[k-1];
            h[0] = {button, switches};
        end
    endtask

    task automatic compare_all();
        check("sw_stable", 32'(sw_stable), 32'(m_q[7:0]));
        check("btn_level", 32'(btn_level), 32'(m_q[8]));
        check("btn_press", 32'(btn_press), 32'(m_press));
        check("sw_snapshot", 32'(sif.sw_snapshot), 32'(m_snap));
        check("snapshot_valid", 32'(sif.snapshot_valid), 32'(m_valid));
`ifdef IO_SNAPSHOT_OVERRUN_EN
        check("overrun", 32'(sif.overrun), 32'(m_ovr));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int presses;
        bit seen;
        sif.snapshot_ack = 1'b0;
        ticks(3);
        check("reset_sw_stable", 32'(sw_stable), 32'h0);
        check("reset_valid", 32'(sif.snapshot_valid), 32'h0);

        // latency: visible after edge SY+DB-1
        rst = 0;
        switches = 8'h15;
        for (int k = 0; k <= SY + DB - 1; k++) begin
            tick();
            check("latency", 32'(sw_stable), (k == SY + DB - 1) ? 32'h15 : 32'h0);
        end

        // 3-cycle glitch never propagates
        switches = 8'h95;
        ticks(3);
        switches = 8'h15;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch", 32'(sw_stable), 32'h15);
        end

        // held press pulses once and captures
        button = 1;
        presses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            presses += int'(btn_press);
        end
        check("press_once", 32'(presses), 32'd1);
        check("snap_15", 32'(sif.sw_snapshot), 32'h15);
        check("valid_1", 32'(sif.snapshot_valid), 32'h1);
        button = 0;
        presses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            presses += int'(btn_press);
        end
        check("release_no_pulse", 32'(presses), 32'd0);

        // second capture without ack overwrites
        switches = 8'h6D;
        ticks(8);
        button = 1;
        ticks(8);
        button = 0;
        ticks(6);
        check("snap_6d", 32'(sif.sw_snapshot), 32'h6D);
        check("valid_still", 32'(sif.snapshot_valid), 32'h1);
`ifdef IO_SNAPSHOT_OVERRUN_EN
        check("overrun_set", 32'(sif.overrun), 32'h1);
`endif
        sif.snapshot_ack = 1;
        tick();
        sif.snapshot_ack = 0;
        check("ack_clears", 32'(sif.snapshot_valid), 32'h0);
        check("ack_holds_snap", 32'(sif.sw_snapshot), 32'h6D);
`ifdef IO_SNAPSHOT_OVERRUN_EN
        check("overrun_clr", 32'(sif.overrun), 32'h0);
`endif
        sif.snapshot_ack = 1;
        ticks(2);
        sif.snapshot_ack = 0;
        check("ack_idle_ignored", 32'(sif.snapshot_valid), 32'h0);

        // press coincident with ack: capture wins
        button = 1;
        ticks(8);
        button = 0;
        ticks(6);
        switches = 8'h33;
        ticks(8);
        button = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = m_press;
        end
        check("press_seen", 32'(seen), 32'h1);
        sif.snapshot_ack = 1;
        tick();
        sif.snapshot_ack = 0;
        check("coinc_valid", 32'(sif.snapshot_valid), 32'h1);
        check("coinc_snap", 32'(sif.sw_snapshot), 32'h33);
`ifdef IO_SNAPSHOT_OVERRUN_EN
        check("coinc_no_ovr", 32'(sif.overrun), 32'h0);
`endif

        // reset mid-debounce discards partial count
        switches = 8'h0F;
        ticks(4);
        rst = 1;
        tick();
        rst = 0;
        check("rst_sw", 32'(sw_stable), 32'h0);
        check("rst_valid", 32'(sif.snapshot_valid), 32'h0);
        check("rst_snap", 32'(sif.sw_snapshot), 32'h0);
        for (int k = 0; k <= SY + DB - 1; k++) begin
            tick();
            check("reaccept", 32'(sw_stable), (k == SY + DB - 1) ? 32'h0F : 32'h0);
        end

        // random phase
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) switches = 8'($urandom);
            if ($urandom_range(5) == 0) button = ~button;
            sif.snapshot_ack = ($urandom_range(3) == 0);
            rst = ($urandom_range(499) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
